// File: rtl/bus_ctrl_pkg.sv
// Shared types, default sizes and decode helper for the bus transfer controller.
package bus_ctrl_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_N_REG = 8;
    localparam int unsigned MAX_REG   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LATCH,
        ST_ERR,
        ST_TURN
    } state_e;

    function automatic logic [MAX_REG-1:0] onehot(input int unsigned idx);
        return MAX_REG'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_transfer_controller_if.sv
// Requester handshake and register-strobe bundle of the bus transfer controller.
interface bus_transfer_controller_if
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned N_REG = DEF_N_REG,
    parameter int unsigned IDX_W = $clog2(N_REG)
);
    localparam int unsigned GID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*IDX_W-1:0] req_src;
    logic [N_REQ*IDX_W-1:0] req_dst;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       req_err;
    logic [N_REG-1:0]       bus_output_en;
    logic [N_REG-1:0]       bus_input_en;
    logic                   busy;
    logic [GID_W-1:0]       grant_id;

    modport master (
        output req_valid, req_src, req_dst,
        input  req_ack, req_err, bus_output_en, bus_input_en, busy, grant_id
    );

    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ack, req_err, bus_output_en, bus_input_en, busy, grant_id
    );

endinterface

// File: rtl/bus_transfer_controller_rr_arbiter.sv
// Combinational round-robin search: first valid requester at or after ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned GID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GID_W-1:0] ptr,
    input  logic             en,
    output logic [GID_W-1:0] grant,
    output logic             any_valid,
    output logic [GID_W-1:0] next_ptr
);

    logic [GID_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = GID_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        any_valid = en && found;
        next_ptr  = GID_W'((32'(grant) + 1) % N_REQ);
    end

endmodule

// File: rtl/bus_transfer_controller.sv
// Round-robin sequencer for register-to-register transfers on the shared tri-state bus.
module bus_transfer_controller
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned N_REG = DEF_N_REG,
    parameter int unsigned IDX_W = $clog2(N_REG)
) (
    input  logic                    ctrl_clock,
    input  logic                    ctrl_reset,
    bus_transfer_controller_if.slave bus
);

    localparam int unsigned GID_W = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [GID_W-1:0] ptr_q, ptr_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic [N_REG-1:0] oe_q, oe_d;
    logic [N_REG-1:0] ie_q, ie_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             busy_q, busy_d;

    logic             arb_en, arb_any;
    logic [GID_W-1:0] arb_grant, arb_next;
    logic [IDX_W-1:0] win_src, win_dst;
    logic             win_ok;

    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_TURN);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (arb_grant),
        .any_valid (arb_any),
        .next_ptr  (arb_next)
    );

    always_comb begin
        win_src = bus.req_src[32'(arb_grant)*IDX_W +: IDX_W];
        win_dst = bus.req_dst[32'(arb_grant)*IDX_W +: IDX_W];
        win_ok  = (win_src != win_dst) && (32'(win_src) < N_REG) && (32'(win_dst) < N_REG);

        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                state_d = ST_IDLE;
                if (arb_any) begin
                    state_d = win_ok ? ST_DRIVE : ST_ERR;
                    ptr_d   = arb_next;
                    grant_d = arb_grant;
                    src_d   = win_src;
                    dst_d   = win_dst;
                end
            end
            ST_DRIVE: state_d = ST_LATCH;
            ST_LATCH: state_d = ST_TURN;
            ST_ERR:   state_d = ST_TURN;
            default:  state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the upcoming state so every output leaves a flop.
        oe_d   = '0;
        ie_d   = '0;
        ack_d  = '0;
        err_d  = '0;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_DRIVE: oe_d = N_REG'(onehot(32'(src_d)));
            ST_LATCH: begin
                oe_d  = N_REG'(onehot(32'(src_d)));
                ie_d  = N_REG'(onehot(32'(dst_d)));
                ack_d = N_REQ'(onehot(32'(grant_d)));
            end
            ST_ERR:   err_d = N_REQ'(onehot(32'(grant_d)));
            default:  ;
        endcase
    end

    always_ff @(posedge ctrl_clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            oe_q    <= '0;
            ie_q    <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            oe_q    <= oe_d;
            ie_q    <= ie_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.bus_output_en = oe_q;
    assign bus.bus_input_en  = ie_q;
    assign bus.req_ack       = ack_q;
    assign bus.req_err       = err_q;
    assign bus.busy          = busy_q;
    assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Bench for bus_transfer_controller: vector table, directed corner sequences and
// random traffic against a timeline model of the transfer schedule.
module tb_bus_transfer_controller;

    localparam int unsigned NQ    = 4;
    localparam int unsigned NR    = 8;
    localparam int unsigned IW    = 4;
    localparam int          DEPTH = 16384;

    logic ctrl_clock = 1'b0;
    logic ctrl_reset = 1'b1;
    always #5 ctrl_clock = ~ctrl_clock;

    bus_transfer_controller_if #(.N_REQ(NQ), .N_REG(NR), .IDX_W(IW)) bif ();

    bus_transfer_controller #(.N_REQ(NQ), .N_REG(NR), .IDX_W(IW)) dut (
        .ctrl_clock (ctrl_clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bif.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int s, input int d);
        bif.req_valid[i]           = 1'b1;
        bif.req_src[i*IW +: IW]    = IW'(s);
        bif.req_dst[i*IW +: IW]    = IW'(d);
    endtask

    task automatic clr_req(input int i);
        bif.req_valid[i] = 1'b0;
    endtask

    // Timeline model: each grant writes the expected strobes into the cycles it will occupy.
    bit [7:0] m_oe  [DEPTH];
    bit [7:0] m_ie  [DEPTH];
    bit [3:0] m_ack [DEPTH];
    bit [3:0] m_err [DEPTH];
    int          cyc      = 0;
    int          next_arb = 0;
    int          busy_end = -1;
    int unsigned m_ptr    = 0;
    int unsigned m_gid    = 0;

    always @(posedge ctrl_clock or posedge ctrl_reset) begin
        int e, w;
        int unsigned s, d;
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_oe[i] = '0; m_ie[i] = '0; m_ack[i] = '0; m_err[i] = '0;
            end
            m_ptr = 0; m_gid = 0; busy_end = -1; next_arb = cyc;
        end else begin
            e   = cyc;
            cyc = cyc + 1;
            if (e >= next_arb && bif.req_valid != '0) begin
                w = -1;
                for (int k = 0; k < NQ; k++)
                    if (w < 0 && bif.req_valid[(m_ptr + k) % NQ]) w = int'((m_ptr + k) % NQ);
                m_ptr = (w + 1) % NQ;
                m_gid = w;
                s = bif.req_src[w*IW +: IW];
                d = bif.req_dst[w*IW +: IW];
                if (s != d && s < NR && d < NR) begin
                    m_oe[e+1]  = 8'(1 << s);
                    m_oe[e+2]  = 8'(1 << s);
                    m_ie[e+2]  = 8'(1 << d);
                    m_ack[e+2] = 4'(1 << w);
                    busy_end   = e + 3;
                    next_arb   = e + 3;
                end else begin
                    m_err[e+1] = 4'(1 << w);
                    busy_end   = e + 2;
                    next_arb   = e + 2;
                end
            end
        end
    end

    logic [7:0] prev_oe = '0;
    always @(negedge ctrl_clock) begin
        if (ctrl_reset) begin
            prev_oe = '0;
        end else begin
            chk("oe",   bif.bus_output_en, m_oe[cyc]);
            chk("ie",   bif.bus_input_en,  m_ie[cyc]);
            chk("ack",  bif.req_ack,       m_ack[cyc]);
            chk("err",  bif.req_err,       m_err[cyc]);
            chk("busy", bif.busy,          (cyc <= busy_end));
            chk("gid",  bif.grant_id,      m_gid);
            chk("oe_onehot", ($countones(bif.bus_output_en) <= 1), 1);
            chk("oe_turnaround",
                (prev_oe != 0 && bif.bus_output_en != 0 && prev_oe != bif.bus_output_en), 0);
            prev_oe = bif.bus_output_en;
        end
    end

    typedef struct {
        int       rq;
        int       src;
        int       dst;
        bit [7:0] oe;
        bit [7:0] ie;
        bit [3:0] ack;
        bit [3:0] err;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{1, 3, 6, 8'h08, 8'h40, 4'b0010, 4'b0000};
        vt[1] = '{2, 4, 4, 8'h00, 8'h00, 4'b0000, 4'b0100};
        vt[2] = '{2, 9, 1, 8'h00, 8'h00, 4'b0000, 4'b0100};
        vt[3] = '{0, 0, 7, 8'h01, 8'h80, 4'b0001, 4'b0000};
        vt[4] = '{3, 7, 0, 8'h80, 8'h01, 4'b1000, 4'b0000};
        vt[5] = '{1, 2, 8, 8'h00, 8'h00, 4'b0000, 4'b0010};
        vt[6] = '{3, 5, 2, 8'h20, 8'h04, 4'b1000, 4'b0000};

        bif.req_valid = '0;
        bif.req_src   = '0;
        bif.req_dst   = '0;
        repeat (3) @(negedge ctrl_clock);
        chk("rst_oe",   bif.bus_output_en, 0);
        chk("rst_ie",   bif.bus_input_en,  0);
        chk("rst_ack",  bif.req_ack,       0);
        chk("rst_err",  bif.req_err,       0);
        chk("rst_busy", bif.busy,          0);
        chk("rst_gid",  bif.grant_id,      0);
        ctrl_reset = 1'b0;
        @(negedge ctrl_clock);

        for (int v = 0; v < 7; v++) begin
            @(negedge ctrl_clock);
            set_req(vt[v].rq, vt[v].src, vt[v].dst);
            @(negedge ctrl_clock);
            chk("v_oe1",   bif.bus_output_en, (vt[v].err == 0) ? vt[v].oe : 8'h00);
            chk("v_ie1",   bif.bus_input_en,  0);
            chk("v_ack1",  bif.req_ack,       0);
            chk("v_err1",  bif.req_err,       vt[v].err);
            chk("v_busy1", bif.busy,          1);
            chk("v_gid",   bif.grant_id,      vt[v].rq);
            if (vt[v].err != 0) clr_req(vt[v].rq);
            @(negedge ctrl_clock);
            chk("v_oe2",   bif.bus_output_en, (vt[v].err == 0) ? vt[v].oe : 8'h00);
            chk("v_ie2",   bif.bus_input_en,  (vt[v].err == 0) ? vt[v].ie : 8'h00);
            chk("v_ack2",  bif.req_ack,       vt[v].ack);
            chk("v_err2",  bif.req_err,       0);
            chk("v_busy2", bif.busy,          1);
            clr_req(vt[v].rq);
            @(negedge ctrl_clock);
            chk("v_oe3",   bif.bus_output_en, 0);
            chk("v_ie3",   bif.bus_input_en,  0);
            chk("v_busy3", bif.busy,          (vt[v].err == 0) ? 1 : 0);
        end

        // Reset asserted in the middle of LATCH.
        @(negedge ctrl_clock);
        set_req(0, 2, 5);
        @(negedge ctrl_clock);
        chk("rl_drive_oe", bif.bus_output_en, 8'h04);
        @(posedge ctrl_clock);
        #2;
        chk("rl_latch_ie", bif.bus_input_en, 8'h20);
        ctrl_reset = 1'b1;
        #1;
        chk("rl_oe",   bif.bus_output_en, 0);
        chk("rl_ie",   bif.bus_input_en,  0);
        chk("rl_ack",  bif.req_ack,       0);
        chk("rl_busy", bif.busy,          0);
        clr_req(0);
        @(negedge ctrl_clock);
        ctrl_reset = 1'b0;
        @(negedge ctrl_clock);
        chk("rl_idle_busy", bif.busy, 0);
        set_req(0, 3, 4);
        set_req(1, 1, 2);
        @(negedge ctrl_clock);
        chk("rl_gid0", bif.grant_id,      0);
        chk("rl_oe0",  bif.bus_output_en, 8'h08);
        @(negedge ctrl_clock);
        clr_req(0);
        @(negedge ctrl_clock);
        @(negedge ctrl_clock);
        chk("rl_gid1", bif.grant_id,      1);
        chk("rl_oe1",  bif.bus_output_en, 8'h02);
        @(negedge ctrl_clock);
        clr_req(1);
        repeat (2) @(negedge ctrl_clock);

        // All requesters held valid: grants rotate 0,1,2,3,0 every three cycles.
        ctrl_reset = 1'b1;
        @(negedge ctrl_clock);
        ctrl_reset = 1'b0;
        @(negedge ctrl_clock);
        for (int i = 0; i < NQ; i++) set_req(i, i, i + 4);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) @(negedge ctrl_clock);
            else repeat (3) @(negedge ctrl_clock);
            chk("rr_gid", bif.grant_id,      k % 4);
            chk("rr_oe",  bif.bus_output_en, 1 << (k % 4));
        end
        bif.req_valid = '0;
        repeat (4) @(negedge ctrl_clock);

        // src changed during DRIVE and valid dropped during LATCH.
        @(negedge ctrl_clock);
        set_req(0, 1, 3);
        @(negedge ctrl_clock);
        chk("sc_oe1", bif.bus_output_en, 8'h02);
        bif.req_src[IW-1:0] = IW'(7);
        @(negedge ctrl_clock);
        chk("sc_oe2", bif.bus_output_en, 8'h02);
        chk("sc_ie2", bif.bus_input_en,  8'h08);
        chk("sc_ack", bif.req_ack,       1);
        clr_req(0);
        @(negedge ctrl_clock);
        chk("sc_oe3",   bif.bus_output_en, 0);
        chk("sc_busy3", bif.busy,          1);
        @(negedge ctrl_clock);
        chk("sc_idle",  bif.busy,          0);

        // Random traffic; requesters renew or drop only when their transfer completes.
        repeat (2000) begin
            @(negedge ctrl_clock);
            #1;
            for (int i = 0; i < NQ; i++) begin
                if (m_ack[cyc][i] || m_err[cyc][i]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(i, int'($urandom_range(9, 0)), int'($urandom_range(9, 0)));
                    else
                        clr_req(i);
                end else if (!bif.req_valid[i] && $urandom_range(3, 0) == 0) begin
                    set_req(i, int'($urandom_range(9, 0)), int'($urandom_range(9, 0)));
                end
            end
        end
        bif.req_valid = '0;
        repeat (6) @(negedge ctrl_clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
